// File: rtl/seg7_scan_if.sv
// Display-side bus of the seven-segment scan driver: load strobe, packed BCD
// digits, decimal-point requests and enable in; active-low pin drives out.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      enable;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output load, digits_in, dp_in, enable,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  load, digits_in, dp_in, enable,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS double-buffered BCD
// digits onto a shared active-low segment bus with leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BUF_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_DARK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      index;
    logic [BUF_W-1:0]      pending_digits;
    logic [NUM_DIGITS-1:0] pending_dp;
    logic [BUF_W-1:0]      active_digits;
    logic [NUM_DIGITS-1:0] active_dp;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic                  tick;
    logic                  last_digit;
    logic                  boundary;
    logic [CNT_W-1:0]      count_next;
    logic [IDX_W-1:0]      index_next;
    logic [BUF_W-1:0]      active_digits_next;
    logic [NUM_DIGITS-1:0] active_dp_next;

    assign tick       = (count == CNT_MAX);
    assign last_digit = (index == IDX_MAX);
    assign boundary   = tick && last_digit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        count_next         = count + CNT_W'(1);
        index_next         = index;
        active_digits_next = active_digits;
        active_dp_next     = active_dp;

        if (tick) begin
            count_next = '0;
            index_next = last_digit ? '0 : index + IDX_W'(1);
        end

        // A load landing on the boundary bypasses pending into the new frame.
        if (boundary) begin
            active_digits_next = bus.load ? bus.digits_in : pending_digits;
            active_dp_next     = bus.load ? bus.dp_in     : pending_dp;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and leading-zero blanking, evaluated on the buffer
    // and index that will be current after this edge.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] zero_from;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [3:0]            sel_code;
    logic                  sel_dp;
    logic                  sel_blank;
    logic                  all_zero;

    always_comb begin
        zero_from  = '0;
        blank_mask = '0;
        all_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (active_digits_next[4*i +: 4] == 4'd0);
            zero_from[i] = all_zero;
            blank_mask[i] = BLANK_LZ && (i > 0) && all_zero;
        end
    end

    always_comb begin
        sel_code  = 4'd0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_next == IDX_W'(i)) begin
                sel_code  = active_digits_next[4*i +: 4];
                sel_dp    = active_dp_next[i];
                sel_blank = blank_mask[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pin values for the next slot
    // ------------------------------------------------------------------
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        seg_next = SEG_DARK;
        dp_next  = 1'b1;
        an_next  = '1;
        if (bus.enable && !sel_blank) begin
            seg_next = decode(sel_code);
            dp_next  = ~sel_dp;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (index_next == IDX_W'(i)) an_next[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            count          <= '0;
            index          <= '0;
            pending_digits <= '0;
            pending_dp     <= '0;
            active_digits  <= '0;
            active_dp      <= '0;
        end else begin
            count         <= count_next;
            index         <= index_next;
            active_digits <= active_digits_next;
            active_dp     <= active_dp_next;
            if (bus.load) begin
                pending_digits <= bus.digits_in;
                pending_dp     <= bus.dp_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_DARK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= seg_next;
            dp_q  <= dp_next;
            an_q  <= an_next;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = boundary && !rst;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4:
// frame timing, double buffering, blanking, dash, dp, enable and async reset.
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    seg7_scan_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stops on the negedge inside a frame-boundary cycle.
    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_done !== 1'b1 && n < 64);
        if (bus.frame_done !== 1'b1)
            check({tag, "_fd_timeout"}, 32'(bus.frame_done), 32'd1);
    endtask

    // Waits for a boundary (optionally loading on it), then checks the first
    // cycle of each slot of the new frame. Returns at slot 3, count 0.
    task automatic check_frame(input string tag,
                               input logic [15:0] exp_an,
                               input logic [27:0] exp_seg,
                               input logic [3:0]  exp_dp,
                               input logic        do_load,
                               input logic [15:0] ld_digits,
                               input logic [3:0]  ld_dp);
        wait_fd(tag);
        if (do_load) begin
            bus.load      = 1'b1;
            bus.digits_in = ld_digits;
            bus.dp_in     = ld_dp;
        end
        @(negedge clk);
        bus.load = 1'b0;
        for (int k = 0; k < ND; k++) begin
            if (k > 0) repeat (RD) @(negedge clk);
            check($sformatf("%s_an%0d", tag, k),  32'(bus.an),  32'(exp_an[4*k +: 4]));
            check($sformatf("%s_seg%0d", tag, k), 32'(bus.seg), 32'(exp_seg[7*k +: 7]));
            check($sformatf("%s_dp%0d", tag, k),  32'(bus.dp),  32'(exp_dp[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.enable    = 1'b1;

        // Held in reset: dark outputs, no frame pulse.
        repeat (3) @(negedge clk);
        check("rst_an",  32'(bus.an),  32'hF);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_dp",  32'(bus.dp),  32'd1);
        check("rst_fd",  32'(bus.frame_done), 32'd0);

        // Digit 0 lit one clock after release, showing "0".
        rst = 1'b0;
        @(negedge clk);
        check("rel_an",  32'(bus.an),  32'hE);
        check("rel_seg", 32'(bus.seg), 32'h40);
        check("rel_dp",  32'(bus.dp),  32'd1);

        // frame_done period is NUM_DIGITS*REFRESH_DIV and lasts one cycle.
        wait_fd("period");
        @(negedge clk);
        check("fd_width", 32'(bus.frame_done), 32'd0);
        n = 1;
        while (bus.frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("fd_period", 32'(n), 32'd16);

        // All-zero value: single "0", upper digits blanked.
        check_frame("zero", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 1'b0, 16'h0, 4'h0);

        // Mid-frame load must not tear the current frame.
        wait_fd("mid");
        @(negedge clk);
        bus.load      = 1'b1;
        bus.digits_in = 16'h0907;
        bus.dp_in     = 4'h0;
        @(negedge clk);
        bus.load = 1'b0;
        check("mid_seg0", 32'(bus.seg), 32'h40);
        check("mid_an0",  32'(bus.an),  32'hE);
        repeat (RD) @(negedge clk);
        check("mid_an1",  32'(bus.an),  32'hF);
        check_frame("f0907", 16'hFBDE, {7'h7F, 7'h10, 7'h40, 7'h78}, 4'hF, 1'b0, 16'h0, 4'h0);

        // Two loads in one frame: last one wins.
        bus.load      = 1'b1;
        bus.digits_in = 16'h1234;
        @(negedge clk);
        bus.digits_in = 16'h5678;
        @(negedge clk);
        bus.load = 1'b0;
        check_frame("f5678", 16'h7BDE, {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, 1'b0, 16'h0, 4'h0);

        // Load on the boundary cycle appears in the very next frame.
        check_frame("bnd0042", 16'hFFDE, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'hF, 1'b1, 16'h0042, 4'h0);

        // Invalid top code shows a dash and keeps zeros below it lit; dp on digit 1.
        check_frame("fA000", 16'h7BDE, {7'h3F, 7'h40, 7'h40, 7'h40}, 4'b1101, 1'b1, 16'hA000, 4'b0010);

        // enable low for 10 clocks: dark, but frame timing undisturbed.
        wait_fd("en");
        bus.enable = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("en_off_an%0d", c), 32'(bus.an), 32'hF);
        end
        check("en_off_seg", 32'(bus.seg), 32'h7F);
        check("en_off_dp",  32'(bus.dp),  32'd1);
        bus.enable = 1'b1;
        @(negedge clk);
        n = 1;
        check("en_resume_an",  32'(bus.an),  32'hB);
        check("en_resume_seg", 32'(bus.seg), 32'h40);
        while (bus.frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("en_fd_gap", 32'(n), 32'd6);

        // Asynchronous reset mid-slot: outputs clear with no clock edge.
        @(negedge clk);
        check("pre_rst_an", 32'(bus.an), 32'hE);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_an",  32'(bus.an),  32'hF);
        check("arst_seg", 32'(bus.seg), 32'h7F);
        check("arst_dp",  32'(bus.dp),  32'd1);
        check("arst_fd",  32'(bus.frame_done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arel_an",  32'(bus.an),  32'hE);
        check("arel_seg", 32'(bus.seg), 32'h40);
        check_frame("post_rst", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 1'b0, 16'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver; successor to the single-digit BCD decoder.
- Takes NUM_DIGITS packed BCD digits and scans them one at a time onto a shared active-low segment bus with active-low digit enables.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing), blanks leading zeros, and shows a dash for invalid codes.
- Sits between the traffic-light countdown logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- REFRESH_DIV, 1000, clock cycles each digit is lit (>=1).
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show every digit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe; capture digits_in and dp_in.
- digits_in  input  4*NUM_DIGITS  packed BCD; bits [3:0] = digit 0 (least significant, rightmost).
- dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- enable  input  1  0 = all digits dark; scanning continues.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, active-low, registered.
- an  output  NUM_DIGITS  digit enables, active-low, one-hot-low, registered.
- frame_done  output  1  one-cycle pulse when digit index wraps to 0.

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high.
- Reset values:
  - seg = 7'b1111111, dp = 1, an = all ones, frame_done = 0.
  - Refresh counter = 0, digit index = 0.
  - Pending and active buffers = all zero.
  - Pending dp and active dp = 0.
- Reset asserted mid-operation: all state clears immediately. The first digit slot after release is digit 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (count == REFRESH_DIV-1). With REFRESH_DIV = 1, tick is asserted every cycle.
- Digit index:
  - Width max(1, clog2(NUM_DIGITS)).
  - On tick, increments modulo NUM_DIGITS: NUM_DIGITS-1 -> 0.
- Pending buffer:
  - When load = 1, pending <= {digits_in, dp_in}.
  - Repeated loads within a frame overwrite pending; last one wins.
- Active buffer:
  - Updated only at a frame boundary, i.e. the cycle where tick = 1 and index = NUM_DIGITS-1.
  - At the boundary, active <= load ? {digits_in, dp_in} : pending. A load coinciding with the boundary therefore takes effect for the new frame.
  - frame_done = 1 for exactly that cycle.
- Decode, used for the digit selected by the next index value:
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001
  - 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000
  - 10..15 -> 0111111 (dash only).
- Blanking:
  - With BLANK_LZ = 1, digit i (i > 0) is blanked when active digits i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 displays a single "0".
  - A blanked digit gives an bit = 1, seg = 1111111, dp = 1.
  - An invalid code never counts as zero.
- Output registration:
  - seg, dp and an are registered and update on the same edge the index changes. They always reflect the newly selected digit, with zero extra latency relative to the index.
  - Outputs are taken from the active buffer after any boundary update in that cycle.
- enable = 0:
  - an = all ones, seg = 1111111, dp = 1 on the next edge.
  - Counter, index, buffers and frame_done keep running.
  - When enable returns to 1, display resumes from the current index.
- dp: dp = ~active_dp[i] when digit i is lit.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4. Release reset with no load -> an cycles 1110, 1101, 1011, 0111 every 4 clocks. Digit 0 shows 1000000; digits 1-3 blanked (an bit held 1, so an = 1110 then 1111 x3). frame_done pulses every 16 clocks.
- Load 16'h0907 mid-frame -> display unchanged until the frame_done cycle. Next frame shows digit0 = 1111000, digit1 = 1000000, digit2 = 0010000, digit3 blanked.
- Load 16'h1234, then 16'h5678 in the same frame -> only 5678 is ever displayed. Load asserted exactly on the boundary cycle -> that value appears in the immediately following frame.
- Digit code 4'hA with BLANK_LZ=1 in position 3, zeros below -> position 3 shows 0111111. Positions 1-2 are not blanked and show 1000000.
- dp_in = 4'b0010 -> dp low only while an = 1101. enable low for 10 clocks -> an = 1111 throughout while frame_done timing is unchanged.
- Assert rst asynchronously mid-slot -> outputs go to reset values without a clock edge. After release, digit 0 is lit within 1 clock and active holds 0.
